// File: rtl/knn_nat_master_pkg.sv
// rtl/knn_nat_master_pkg.sv - shared states, register map and helpers for the KNN native-bus initiator
package knn_nat_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_X   = 3'd1,
    ST_WR_Y   = 3'd2,
    ST_WR_ID  = 3'd3,
    ST_RD_RES = 3'd4,
    ST_RESP   = 3'd5
  } knn_state_e;

  localparam int KNN_A_X   = 0;
  localparam int KNN_A_Y   = 1;
  localparam int KNN_A_ID  = 2;
  localparam int KNN_A_RES = 3;

  function automatic logic is_access(input knn_state_e s);
    return (s == ST_WR_X) || (s == ST_WR_Y) || (s == ST_WR_ID) || (s == ST_RD_RES);
  endfunction

endpackage

// File: rtl/knn_pt_fifo.sv
// rtl/knn_pt_fifo.sv - show-ahead synchronous point FIFO with full/empty flags
module knn_pt_fifo #(
  parameter int WIDTH      = 66,
  parameter int LOG2_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0]    mem [2**LOG2_DEPTH];
  logic [LOG2_DEPTH:0] wr_ptr;
  logic [LOG2_DEPTH:0] rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[LOG2_DEPTH] != rd_ptr[LOG2_DEPTH]) &&
                 (wr_ptr[LOG2_DEPTH-1:0] == rd_ptr[LOG2_DEPTH-1:0]);
  assign dout  = mem[rd_ptr[LOG2_DEPTH-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[LOG2_DEPTH-1:0]] <= din;
  end

endmodule

// File: rtl/knn_nat_master.sv
// rtl/knn_nat_master.sv - native-bus initiator feeding buffered points to the KNN peripheral
module knn_nat_master
  import knn_nat_master_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 2,
  parameter int FIFO_LOG2 = 2,
  parameter int TIMEOUT   = 255,
  parameter int A_X       = KNN_A_X,
  parameter int A_Y       = KNN_A_Y,
  parameter int A_ID      = KNN_A_ID,
  parameter int A_RES     = KNN_A_RES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pt_valid,
  output logic                pt_ready,
  input  logic [DATA_W-1:0]   pt_x,
  input  logic [DATA_W-1:0]   pt_y,
  input  logic [ID_W-1:0]     pt_id,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DATA_W-1:0]   res_data,
  output logic [ID_W-1:0]     res_id,
  output logic                res_err,
  output logic                busy
);

  localparam int PT_W = 2*DATA_W + ID_W;

  knn_state_e        state, state_nxt;
  logic              fifo_full, fifo_empty, push, pop;
  logic [PT_W-1:0]   fifo_dout;
  logic [DATA_W-1:0] x_r, y_r;
  logic [7:0]        tmo_cnt;
  logic              in_acc, acc_done, acc_tmo;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  assign pt_ready = ~fifo_full;
  assign push     = pt_valid & ~fifo_full;

  knn_pt_fifo #(.WIDTH(PT_W), .LOG2_DEPTH(FIFO_LOG2)) u_pt_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   ({pt_x, pt_y, pt_id}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A completion arriving in the timeout cycle wins because acc_tmo requires !m_ready.
  assign in_acc    = is_access(state);
  assign acc_done  = in_acc & m_valid & m_ready;
  assign acc_tmo   = in_acc & m_valid & ~m_ready & (tmo_cnt == 8'(TIMEOUT-1));
  assign res_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE) | ~fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE:   if (!fifo_empty) begin
                   pop       = 1'b1;
                   state_nxt = ST_WR_X;
                 end
      ST_WR_X:   if (acc_done) state_nxt = ST_WR_Y;
      ST_WR_Y:   if (acc_done) state_nxt = ST_WR_ID;
      ST_WR_ID:  if (acc_done) state_nxt = ST_RD_RES;
      ST_RD_RES: if (acc_done) state_nxt = ST_RESP;
      ST_RESP:   if (res_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (acc_tmo) state_nxt = ST_RESP;
  end

  always_comb begin
    acc_addr  = ADDR_W'(A_RES);
    acc_wdata = '0;
    case (state)
      ST_WR_X:  begin acc_addr = ADDR_W'(A_X);  acc_wdata = x_r;            end
      ST_WR_Y:  begin acc_addr = ADDR_W'(A_Y);  acc_wdata = y_r;            end
      ST_WR_ID: begin acc_addr = ADDR_W'(A_ID); acc_wdata = DATA_W'(res_id); end
      default:  ;
    endcase
  end

  // The first cycle in each access state has m_valid low, giving the mandatory idle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_wstrb  <= '0;
      tmo_cnt  <= '0;
      x_r      <= '0;
      y_r      <= '0;
      res_id   <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
    end else begin
      if (pop) begin
        {x_r, y_r, res_id} <= fifo_dout;
        res_data           <= '0;
        res_err            <= 1'b0;
      end
      if (acc_done) begin
        m_valid <= 1'b0;
        if (state == ST_RD_RES) res_data <= m_rdata;
      end else if (acc_tmo) begin
        m_valid  <= 1'b0;
        res_data <= '0;
        res_err  <= 1'b1;
      end else if (in_acc && !m_valid) begin
        m_valid <= 1'b1;
        tmo_cnt <= '0;
        m_addr  <= acc_addr;
        m_wdata <= acc_wdata;
        m_wstrb <= (state == ST_RD_RES) ? '0 : '1;
      end else if (m_valid) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_knn_nat_master.sv
// tb/tb_knn_nat_master.sv - randomized self-checking bench with responder and point-stream reference model
module tb_knn_nat_master;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [1:0]  id;
  } pt_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  id;
    logic        err;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pt_valid = 1'b0;
  logic        pt_ready;
  logic [31:0] pt_x = '0;
  logic [31:0] pt_y = '0;
  logic [1:0]  pt_id = '0;
  logic        m_valid;
  logic [3:0]  m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata = '0;
  logic        m_ready = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic [1:0]  res_id;
  logic        res_err;
  logic        busy;

  knn_nat_master dut (
    .clk(clk), .rst_n(rst_n),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y), .pt_id(pt_id),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_id(res_id), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_pushed = 0;
  int    n_resp = 0;
  pt_t   bus_q[$];
  resp_t exp_q[$];

  int          fixed_delay = 1;
  bit          fixed_result_en = 1'b0;
  logic [31:0] fixed_result = '0;
  bit          stall_wry = 1'b0;
  bit          hold_resp = 1'b0;
  bit          saw_full = 1'b0;
  logic [31:0] last_data;
  logic [1:0]  last_id;
  logic        last_err;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Responder model: checks each access against the point sequence it expects and answers after a delay.
  initial begin
    bit          in_acc = 1'b0;
    int          acc_idx = 0;
    int          wait_cnt = 0;
    int          dly = 0;
    pt_t         cur = '0;
    resp_t       e;
    logic [3:0]  ea, rec_addr;
    logic [31:0] ew, rec_wdata, rd;
    logic [3:0]  es;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_ready = 1'b0;
        in_acc  = 1'b0;
        acc_idx = 0;
        bus_q.delete();
      end else if (m_ready) begin
        m_ready = 1'b0;
        in_acc  = 1'b0;
        check_eq("bus_gap", m_valid, 0);
        acc_idx = (acc_idx + 1) % 4;
      end else if (in_acc && !m_valid) begin
        check_eq("tmo_wait_cycles", wait_cnt, 255);
        in_acc  = 1'b0;
        acc_idx = 0;
        e.data = '0; e.id = cur.id; e.err = 1'b1;
        exp_q.push_back(e);
      end else if (m_valid) begin
        if (!in_acc) begin
          in_acc   = 1'b1;
          wait_cnt = 0;
          if (acc_idx == 0) begin
            if (bus_q.size() == 0) check_eq("bus_unexpected_access", 1, 0);
            else cur = bus_q.pop_front();
          end
          es = 4'hF;
          case (acc_idx)
            0:       begin ea = 4'd0; ew = cur.x; end
            1:       begin ea = 4'd1; ew = cur.y; end
            2:       begin ea = 4'd2; ew = {30'd0, cur.id}; end
            default: begin ea = 4'd3; ew = '0; es = 4'h0; end
          endcase
          check_eq("bus_addr", m_addr, ea);
          if (acc_idx < 3) check_eq("bus_wdata", m_wdata, ew);
          check_eq("bus_wstrb", m_wstrb, es);
          rec_addr  = m_addr;
          rec_wdata = m_wdata;
          if (stall_wry && acc_idx == 1) begin
            dly = 100000;
            stall_wry = 1'b0;
          end else if (fixed_delay >= 0) dly = fixed_delay;
          else dly = $urandom_range(0, 20);
        end
        wait_cnt++;
        if (wait_cnt > dly) begin
          check_eq("bus_addr_stable", m_addr, rec_addr);
          check_eq("bus_wdata_stable", m_wdata, rec_wdata);
          rd = fixed_result_en ? fixed_result : $urandom;
          m_rdata = rd;
          m_ready = 1'b1;
          if (acc_idx == 3) begin
            e.data = rd; e.id = cur.id; e.err = 1'b0;
            exp_q.push_back(e);
          end
        end
      end
    end
  end

  // Response consumer: random back-pressure, compares each response with the model queue.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        res_ready = 1'b0;
        exp_q.delete();
      end else if (res_ready) begin
        res_ready = 1'b0;
      end else if (res_valid && !hold_resp && ($urandom_range(0, 2) != 0)) begin
        if (exp_q.size() == 0) check_eq("resp_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check_eq("resp_data", res_data, e.data);
          check_eq("resp_id", res_id, e.id);
          check_eq("resp_err", res_err, e.err);
        end
        last_data = res_data;
        last_id   = res_id;
        last_err  = res_err;
        n_resp++;
        res_ready = 1'b1;
      end
    end
  end

  task automatic push(input logic [31:0] x, input logic [31:0] y, input logic [1:0] id);
    int  guard = 0;
    pt_t p;
    pt_valid = 1'b1; pt_x = x; pt_y = y; pt_id = id;
    while (!pt_ready && guard < 3000) begin
      saw_full = 1'b1;
      @(negedge clk);
      guard++;
    end
    check_eq("push_accept_bound", pt_ready, 1);
    p.x = x; p.y = y; p.id = id;
    bus_q.push_back(p);
    n_pushed++;
    @(negedge clk);
    pt_valid = 1'b0;
  endtask

  task automatic wait_resp(input int n, input int budget);
    int c = 0;
    while (n_resp < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check_eq("resp_count", n_resp, n);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int          c;
    int          bad;
    logic [31:0] d;
    repeat (3) @(negedge clk);
    check_eq("rst_pt_ready", pt_ready, 1);
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_m_addr", m_addr, 0);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_res_data", res_data, 0);
    check_eq("rst_res_err", res_err, 0);
    check_eq("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    fixed_delay = 1; fixed_result_en = 1'b1; fixed_result = 32'h2A;
    push(32'd3, 32'd4, 2'd1);
    wait_resp(n_pushed, 300);
    check_eq("single_data", last_data, 32'h2A);
    check_eq("single_id", last_id, 1);
    check_eq("single_err", last_err, 0);
    fixed_result_en = 1'b0;

    saw_full = 1'b0;
    for (int i = 0; i < 6; i++) push($urandom, $urandom, 2'(i));
    check_eq("fifo_backpressure_seen", saw_full, 1);
    wait_resp(n_pushed, 1000);

    fixed_delay = -1;
    for (int i = 0; i < 8; i++) push($urandom, $urandom, 2'($urandom_range(0, 3)));
    wait_resp(n_pushed, 3000);
    check_eq("idle_after_random", busy, 0);

    fixed_delay = 2;
    stall_wry = 1'b1;
    push($urandom, $urandom, 2'd2);
    push($urandom, $urandom, 2'd3);
    wait_resp(n_pushed, 1000);
    check_eq("after_tmo_err", last_err, 0);
    check_eq("after_tmo_id", last_id, 3);

    hold_resp = 1'b1;
    push($urandom, $urandom, 2'd0);
    c = 0;
    while (!res_valid && c < 200) begin
      @(negedge clk);
      c++;
    end
    check_eq("hold_res_valid", res_valid, 1);
    d = res_data;
    for (int i = 0; i < 4; i++) push($urandom, $urandom, 2'(i));
    check_eq("hold_fifo_full", pt_ready, 0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (!res_valid || res_data !== d || m_valid || pt_ready) bad++;
      @(negedge clk);
    end
    check_eq("hold_stable", bad, 0);
    hold_resp = 1'b0;
    wait_resp(n_pushed, 2000);

    fixed_delay = 10;
    for (int i = 0; i < 3; i++) push($urandom, $urandom, 2'(i));
    c = 0;
    while (!(m_valid && m_addr == 4'd3) && c < 500) begin
      @(negedge clk);
      c++;
    end
    check_eq("reach_rd_res", m_addr, 3);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_m_valid", m_valid, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_pt_ready", pt_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_pushed = 0;
    n_resp = 0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_valid || res_valid) bad++;
    end
    check_eq("post_rst_quiet", bad, 0);
    check_eq("post_rst_resp", n_resp, 0);
    check_eq("post_rst_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
